audio_tone_serializer: RTL and testbench

Consumer end of the BGM note interface. Takes per-channel half-period dividers and an amplitude from the note source (BGM or SFX mux), and synthesises a square-wave tone per channel. It serialises the 16-bit stereo samples onto the Pmod I2S DAC pins (mclk/lrck/sck/sdin). It sits between the audio note mux and the top-level audio pins.

---
 rtl/audio_tone_serializer_if.sv | 39 +++
 rtl/audio_tone_serializer.sv | 102 ++++++++++
 tb/tb_audio_tone_serializer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_tone_serializer_if.sv
// Note-source to tone-serializer bundle plus the DAC pin outputs.
// master: note source side; slave: the serializer.
interface audio_tone_serializer_if #(
  parameter int DIV_W = 22
);
  logic [DIV_W-1:0] note_div_left;
  logic [DIV_W-1:0] note_div_right;
  logic [15:0]      amplitude;
  logic             mute;
  logic             audio_mclk;
  logic             audio_lrck;
  logic             audio_sck;
  logic             audio_sdin;
  logic             frame_tick;

  modport master (
    output note_div_left,
    output note_div_right,
    output amplitude,
    output mute,
    input  audio_mclk,
    input  audio_lrck,
    input  audio_sck,
    input  audio_sdin,
    input  frame_tick
  );

  modport slave (
    input  note_div_left,
    input  note_div_right,
    input  amplitude,
    input  mute,
    output audio_mclk,
    output audio_lrck,
    output audio_sck,
    output audio_sdin,
    output frame_tick
  );
endinterface

// File: rtl/audio_tone_serializer.sv
// Dual square-wave tone synth feeding a left-justified I2S DAC.
// Ports: clk; rst (async, active-low); bus (slave): note_div_left/right,
// amplitude, mute in; audio_mclk/lrck/sck/sdin, frame_tick out.
module audio_tone_serializer #(
  parameter int DIV_W   = 22,
  parameter int MIN_DIV = 2
) (
  input logic                    clk,
  input logic                    rst,
  audio_tone_serializer_if.slave bus
);

  logic [8:0]       fcnt;
  logic [8:0]       fnext;
  logic             load;
  logic [DIV_W-1:0] div  [2];
  logic [DIV_W-1:0] tcnt [2];
  logic [1:0]       phase;
  logic [15:0]      amp_eff;
  logic [15:0]      smp  [2];
  logic [15:0]      nxt_l;
  logic [15:0]      nxt_r;
  logic [15:0]      shadow_l;
  logic [15:0]      shadow_r;
  logic [15:0]      word;
  logic             sdin;

  assign div[0]  = bus.note_div_left;
  assign div[1]  = bus.note_div_right;
  assign fnext   = fcnt + 9'd1;
  assign load    = &fcnt;
  assign amp_eff = bus.amplitude[15] ? 16'h7fff
                                     : bus.amplitude;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      smp[i] = '0;
      if (div[i] >= DIV_W'(MIN_DIV))
        smp[i] = phase[i] ? 16'h0 - amp_eff
                          : amp_eff;
    end
  end

  assign nxt_l = bus.mute ? 16'h0 : smp[0];
  assign nxt_r = bus.mute ? 16'h0 : smp[1];

  // sdin is registered one slot early, so on the latch
  // cycle the word being loaded supplies the first bit.
  always_comb begin
    word = shadow_l;
    unique case (1'b1)
      load:     word = nxt_l;
      fnext[8]: word = shadow_r;
      default:  word = shadow_l;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt     <= '0;
      shadow_l <= '0;
      shadow_r <= '0;
      sdin     <= 1'b0;
    end else begin
      fcnt <= fnext;
      if (load) begin
        shadow_l <= nxt_l;
        shadow_r <= nxt_r;
      end
      sdin <= word[~fnext[7:4]];
    end
  end

  // >= rather than == so a shrinking divider wraps at once
  // instead of running the counter all the way round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        tcnt[i] <= '0;
      phase <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (div[i] < DIV_W'(MIN_DIV)) begin
          tcnt[i]  <= '0;
          phase[i] <= 1'b0;
        end else if (tcnt[i] >= div[i] - DIV_W'(1)) begin
          tcnt[i]  <= '0;
          phase[i] <= ~phase[i];
        end else begin
          tcnt[i] <= tcnt[i] + DIV_W'(1);
        end
      end
    end
  end

  assign bus.audio_mclk = fcnt[1];
  assign bus.audio_sck  = fcnt[3];
  assign bus.audio_lrck = ~fcnt[8];
  assign bus.audio_sdin = sdin;
  assign bus.frame_tick = load;

endmodule

// File: tb/tb_audio_tone_serializer.sv
// Bench for audio_tone_serializer: directed scenarios plus random
// stimulus checked cycle by cycle against a timestamp-based model.
module tb_audio_tone_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  audio_tone_serializer_if #(.DIV_W(22)) bus ();

  audio_tone_serializer #(
    .DIV_W(22),
    .MIN_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: frame position, shadow words, and per channel
  // the phase plus the edge index where the current half-period began.
  int          m_q;
  longint      m_e;
  longint      m_start [2];
  bit          m_ph    [2];
  logic [15:0] m_shl;
  logic [15:0] m_shr;
  logic [15:0] m_amp;
  logic [15:0] m_s     [2];
  longint      m_d     [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = 0;
      m_e = 0;
      m_shl = 16'h0;
      m_shr = 16'h0;
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = 1'b0;
        m_start[i] = 0;
      end
    end else begin
      m_d[0] = longint'(bus.note_div_left);
      m_d[1] = longint'(bus.note_div_right);
      m_amp = bus.amplitude > 16'h7fff ? 16'h7fff : bus.amplitude;
      for (int i = 0; i < 2; i++)
        m_s[i] = (m_d[i] < 2) ? 16'h0
               : (m_ph[i] ? 16'h0 - m_amp : m_amp);
      if (m_q == 511) begin
        m_shl = bus.mute ? 16'h0 : m_s[0];
        m_shr = bus.mute ? 16'h0 : m_s[1];
      end
      for (int i = 0; i < 2; i++) begin
        if (m_d[i] < 2) begin
          m_ph[i] = 1'b0;
          m_start[i] = m_e + 1;
        end else if (m_e - m_start[i] >= m_d[i] - 1) begin
          m_ph[i] = ~m_ph[i];
          m_start[i] = m_e + 1;
        end
      end
      m_e = m_e + 1;
      m_q = (m_q + 1) % 512;
    end
  end

  task automatic set_in(input logic [21:0] dl, input logic [21:0] dr,
                        input logic [15:0] amp, input logic mt);
    bus.note_div_left  = dl;
    bus.note_div_right = dr;
    bus.amplitude      = amp;
    bus.mute           = mt;
  endtask

  // After this, zero clock edges have elapsed since release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Leaves the bench on the negedge where frame_tick is high.
  task automatic sync_frame(input string tag);
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) break;
    end
    n_vec++;
    if (i >= 600) begin
      n_err++;
      $display("FAIL %s sync: frame_tick not seen within 600 clk", tag);
    end
  endtask

  // Captures one frame starting on the negedge after a latch; sdin
  // is sampled where sck has just risen (position mod 16 == 8).
  task automatic get_frame(input int mute_at, input logic mute_val,
                           output logic [15:0] l, output logic [15:0] r);
    int idx;
    l = 16'h0;
    r = 16'h0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if (k % 16 == 8) begin
        idx = 15 - (k % 256) / 16;
        if (k < 256) l[idx] = bus.audio_sdin;
        else         r[idx] = bus.audio_sdin;
      end
      if (k == mute_at) bus.mute = mute_val;
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    int i;
    set_in(22'd0, 22'd0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    got = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
           bus.audio_sdin, bus.frame_tick};
    n_vec++;
    if (got !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_initial: got %b want 00100", got);
    end
    set_in(22'd3, 22'd5, 16'h7fff, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i > 600 && bus.audio_mclk && bus.audio_sck && !bus.audio_lrck)
        break;
    end
    #2 rst = 1'b0;
    #1;
    got = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
           bus.audio_sdin, bus.frame_tick};
    n_vec++;
    if (got !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_async: got %b want 00100", got);
    end
    repeat (3) @(negedge clk);
    got = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
           bus.audio_sdin, bus.frame_tick};
    n_vec++;
    if (got !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_held: got %b want 00100", got);
    end
  endtask

  task automatic test_clocks();
    logic [3:0] got;
    logic [3:0] exp;
    int q;
    set_in(22'd0, 22'd0, 16'h0, 1'b0);
    do_reset();
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      q = k % 512;
      exp = {1'((q / 2) % 2), 1'((q / 8) % 2),
             1'(q < 256), 1'(q == 511)};
      got = {bus.audio_mclk, bus.audio_sck,
             bus.audio_lrck, bus.frame_tick};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL clocks k=%0d: got %b want %b", k, got, exp);
      end
    end
  endtask

  // Phase before edge e is floor(e/d) mod 2 for a constant divider d
  // held since reset; latch edges are 511 + 512*f.
  task automatic test_tone();
    logic [15:0] l, r, el, er;
    longint e;
    set_in(22'd4, 22'd6, 16'h1000, 1'b0);
    do_reset();
    sync_frame("tone");
    for (int f = 0; f < 4; f++) begin
      get_frame(-1, 1'b0, l, r);
      e = 511 + 512 * f;
      el = ((e / 4) % 2 != 0) ? 16'hf000 : 16'h1000;
      er = ((e / 6) % 2 != 0) ? 16'hf000 : 16'h1000;
      n_vec++;
      if (l !== el || r !== er) begin
        n_err++;
        $display("FAIL tone f=%0d: got %h/%h want %h/%h",
                 f, l, r, el, er);
      end
    end
  endtask

  task automatic test_serial_word();
    logic [15:0] l, r;
    set_in(22'd1_000_000, 22'd0, 16'h2a5a, 1'b0);
    do_reset();
    get_frame(-1, 1'b0, l, r);
    n_vec++;
    if (l !== 16'h0 || r !== 16'h0) begin
      n_err++;
      $display("FAIL serial_first_frame: got %h/%h want 0000/0000", l, r);
    end
    get_frame(-1, 1'b0, l, r);
    n_vec++;
    if (l !== 16'h2a5a || r !== 16'h0) begin
      n_err++;
      $display("FAIL serial_word: got %h/%h want 2a5a/0000", l, r);
    end
  endtask

  task automatic test_silence_saturation();
    logic [15:0] l, r;
    logic [15:0] exp [3];
    exp[0] = 16'h7fff;
    exp[1] = 16'h7fff;
    exp[2] = 16'h8001;
    set_in(22'd1, 22'd1, 16'h9000, 1'b0);
    do_reset();
    get_frame(-1, 1'b0, l, r);
    get_frame(-1, 1'b0, l, r);
    n_vec++;
    if (l !== 16'h0 || r !== 16'h0) begin
      n_err++;
      $display("FAIL silence: got %h/%h want 0000/0000", l, r);
    end
    bus.note_div_left  = 22'd700;
    bus.note_div_right = 22'd700;
    for (int f = 0; f < 3; f++) begin
      get_frame(-1, 1'b0, l, r);
      n_vec++;
      if (l !== exp[f] || r !== exp[f]) begin
        n_err++;
        $display("FAIL saturate f=%0d: got %h/%h want %h", f, l, r, exp[f]);
      end
    end
  endtask

  task automatic test_mute();
    logic [15:0] l, r;
    set_in(22'd1_000_000, 22'd1_000_000, 16'h1234, 1'b0);
    do_reset();
    get_frame(-1, 1'b0, l, r);
    get_frame(100, 1'b1, l, r);
    n_vec++;
    if (l !== 16'h1234 || r !== 16'h1234) begin
      n_err++;
      $display("FAIL mute_current: got %h/%h want 1234/1234", l, r);
    end
    get_frame(50, 1'b0, l, r);
    n_vec++;
    if (l !== 16'h0 || r !== 16'h0) begin
      n_err++;
      $display("FAIL mute_silenced: got %h/%h want 0000/0000", l, r);
    end
    get_frame(-1, 1'b0, l, r);
    n_vec++;
    if (l !== 16'h1234 || r !== 16'h1234) begin
      n_err++;
      $display("FAIL mute_resume: got %h/%h want 1234/1234", l, r);
    end
  endtask

  // Divider drops 1000->10 with 500 counts done: toggles at edges
  // 500, 510, 520, ... so latches at 511/1023/1535 see +A, -A, +A.
  task automatic test_shrink();
    logic [15:0] l, r;
    logic [15:0] exp [3];
    exp[0] = 16'h0500;
    exp[1] = 16'hfb00;
    exp[2] = 16'h0500;
    set_in(22'd1000, 22'd0, 16'h0500, 1'b0);
    do_reset();
    repeat (501) @(negedge clk);
    bus.note_div_left = 22'd10;
    sync_frame("shrink");
    for (int f = 0; f < 3; f++) begin
      get_frame(-1, 1'b0, l, r);
      n_vec++;
      if (l !== exp[f] || r !== 16'h0) begin
        n_err++;
        $display("FAIL shrink f=%0d: got %h/%h want %h/0000",
                 f, l, r, exp[f]);
      end
    end
  endtask

  function automatic logic [21:0] rand_div();
    unique case ($urandom_range(0, 3))
      0:       return 22'($urandom_range(0, 3));
      1:       return 22'($urandom_range(2, 40));
      2:       return 22'($urandom_range(100, 3000));
      default: return 22'($urandom_range(41, 99));
    endcase
  endfunction

  task automatic test_random();
    logic [4:0] got;
    logic [4:0] exp;
    logic       bit_exp;
    int         q;
    int         idx;
    set_in(rand_div(), rand_div(), 16'($urandom), 1'b0);
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      for (int c = 0; c < int'($urandom_range(1, 400)); c++) begin
        @(negedge clk);
        q = m_q;
        idx = 15 - (q % 256) / 16;
        bit_exp = (q >= 256) ? m_shr[idx] : m_shl[idx];
        exp = {1'((q / 2) % 2), 1'((q / 8) % 2), 1'(q < 256),
               bit_exp, 1'(q == 511)};
        got = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck,
               bus.audio_sdin, bus.frame_tick};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL random seg=%0d q=%0d: got %b want %b",
                   seg, q, got, exp);
        end
      end
      set_in(rand_div(), rand_div(), 16'($urandom),
             1'($urandom_range(0, 4) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_tone();
    test_serial_word();
    test_silence_saturation();
    test_mute();
    test_shrink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
